// File: rtl/sumb_bscan_chain.sv
// Boundary-scan controller for a bank of GPIO pads: muxes core/pad controls and
// runs a capture/shift/update chain with 3 cells per pad (DI, OEN, DO).
module sumb_bscan_chain #(
  parameter int NPAD = 4
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic [1:0]      MODE,
  input  logic            CAPTURE,
  input  logic            SHIFT,
  input  logic            UPDATE,
  input  logic            TDI,
  output logic            TDO,
  input  logic [NPAD-1:0] CORE_DO,
  input  logic [NPAD-1:0] CORE_OEN,
  input  logic [NPAD-1:0] CORE_IE,
  input  logic [NPAD-1:0] CORE_REN,
  input  logic [NPAD-1:0] PAD_DI,
  output logic [NPAD-1:0] PAD_DO,
  output logic [NPAD-1:0] PAD_OEN,
  output logic [NPAD-1:0] PAD_REN,
  output logic [NPAD-1:0] PAD_IE,
  output logic [NPAD-1:0] PAD_BSEN,
  output logic [NPAD-1:0] CORE_DI,
  output logic            DONE,
  output logic            ERR
);

  localparam int L  = 3 * NPAD;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(L);

  typedef enum logic [1:0] {
    MODE_FUNC   = 2'b00,
    MODE_SAMPLE = 2'b01,
    MODE_EXTEST = 2'b10,
    MODE_HIGHZ  = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(MODE);

  logic [L-1:0]    sr_reg;
  logic [CW-1:0]   cnt_reg;
  logic            err_reg;
  logic [NPAD-1:0] ur_do_reg, ur_oen_reg;
  logic [NPAD-1:0] pad_do_reg, pad_oen_reg, pad_ren_reg, pad_ie_reg, pad_bsen_reg;
  logic [NPAD-1:0] pad_do_next, pad_oen_next, pad_ren_next, pad_ie_next, pad_bsen_next;

  logic [L-1:0]    cap_vec;
  logic [NPAD-1:0] sr_do, sr_oen;

  genvar gi;
  generate
    for (gi = 0; gi < NPAD; gi++) begin : g_cell
      assign cap_vec[3*gi]   = PAD_DI[gi];
      assign cap_vec[3*gi+1] = pad_oen_reg[gi];
      assign cap_vec[3*gi+2] = pad_do_reg[gi];
      assign sr_do[gi]       = sr_reg[3*gi+2];
      assign sr_oen[gi]      = sr_reg[3*gi+1];
    end
  endgenerate

  logic multi_strobe;
  assign multi_strobe = (CAPTURE & SHIFT) | (CAPTURE & UPDATE) | (UPDATE & SHIFT);

  always_comb begin
    pad_do_next   = CORE_DO;
    pad_oen_next  = CORE_OEN;
    pad_ren_next  = CORE_REN;
    pad_ie_next   = CORE_IE;
    pad_bsen_next = '0;
    case (mode)
      MODE_EXTEST: begin
        pad_do_next   = ur_do_reg;
        pad_oen_next  = ur_oen_reg;
        pad_bsen_next = '1;
      end
      MODE_HIGHZ: begin
        pad_do_next  = '0;
        pad_oen_next = '1;
        pad_ren_next = '0;
        pad_ie_next  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      sr_reg       <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      ur_do_reg    <= '0;
      ur_oen_reg   <= '1;
      pad_do_reg   <= '0;
      pad_oen_reg  <= '1;
      pad_ren_reg  <= '0;
      pad_ie_reg   <= '0;
      pad_bsen_reg <= '0;
    end else begin
      pad_do_reg   <= pad_do_next;
      pad_oen_reg  <= pad_oen_next;
      pad_ren_reg  <= pad_ren_next;
      pad_ie_reg   <= pad_ie_next;
      pad_bsen_reg <= pad_bsen_next;

      // Only the highest-priority strobe acts; any overlap is a protocol error.
      if (CAPTURE) begin
        sr_reg  <= cap_vec;
        cnt_reg <= '0;
      end else if (UPDATE) begin
        ur_do_reg  <= sr_do;
        ur_oen_reg <= sr_oen;
      end else if (SHIFT) begin
        sr_reg <= {TDI, sr_reg[L-1:1]};
        if (cnt_reg != CNT_FULL) cnt_reg <= cnt_reg + 1'b1;
      end

      if (multi_strobe || (UPDATE && cnt_reg != CNT_FULL)) err_reg <= 1'b1;
    end
  end

  assign TDO      = sr_reg[0];
  assign DONE     = (cnt_reg == CNT_FULL);
  assign ERR      = err_reg;
  assign PAD_DO   = pad_do_reg;
  assign PAD_OEN  = pad_oen_reg;
  assign PAD_REN  = pad_ren_reg;
  assign PAD_IE   = pad_ie_reg;
  assign PAD_BSEN = pad_bsen_reg;
  assign CORE_DI  = MODE[1] ? '0 : PAD_DI;

endmodule
